// File: rtl/crp16_alu_pkg.sv
// Shared opcode encoding and FSM state type for the CRP16 multi-cycle ALU.
package crp16_alu_pkg;

    localparam logic [3:0] OP_LSR   = 4'd0;
    localparam logic [3:0] OP_ASR   = 4'd1;
    localparam logic [3:0] OP_LSL   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_ADC   = 4'd8;
    localparam logic [3:0] OP_SBC   = 4'd9;
    localparam logic [3:0] OP_ROR   = 4'd10;
    localparam logic [3:0] OP_ROL   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_MULHU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/crp16_addsub.sv
// Combinational adder/subtractor with carry-in, optional b inversion,
// carry-out and signed overflow.
module crp16_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inv,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] be;

    assign be = inv ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, cin};
    // Same-sign inputs to the adder producing a different-sign sum.
    assign ovf = (a[WIDTH-1] == be[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/crp16_alu_mc.sv
// CRP16 multi-cycle ALU: single-cycle logic/arith, iterative shifts,
// rotates and shift-add multiply behind a valid/ready handshake.
module crp16_alu_mc
    import crp16_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       select,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);

    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc, lo, ry, res;
    logic [3:0]       rop;
    logic [SHW:0]     cnt;
    logic             cr, vr;

    logic [WIDTH-1:0] as_a, as_b, as_sum;
    logic             as_inv, as_cin, as_cout, as_ovf;

    logic [WIDTH-1:0] imm_res;
    logic             imm_c, imm_v;
    logic [SHW-1:0]   amt;
    logic             is_mul, is_sh, go_busy, last;

    logic [2*WIDTH:0] mstep;
    logic [WIDTH-1:0] nxt_acc, nxt_lo, fin_res;
    logic             nxt_sc, fin_c, fin_v;

    crp16_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .inv  (as_inv),
        .cin  (as_cin),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    assign amt    = y[SHW-1:0];
    assign is_mul = (select == OP_MUL) || (select == OP_MULHU);
    assign is_sh  = (select == OP_LSR) || (select == OP_ASR) ||
                    (select == OP_LSL) || (select == OP_ROR) ||
                    (select == OP_ROL);
    assign go_busy = is_mul || (is_sh && (amt != '0));
    assign last    = (cnt == (SHW+1)'(1));

    // The adder serves the request operands in IDLE and the
    // multiply accumulate step in BUSY.
    always_comb begin
        as_a    = x;
        as_b    = y;
        as_inv  = 1'b0;
        as_cin  = 1'b0;
        imm_res = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        if (state == S_BUSY) begin
            as_a = acc;
            as_b = ry;
        end else begin
            case (select)
                OP_SUB: begin
                    as_inv = 1'b1;
                    as_cin = 1'b1;
                end
                OP_ADC: as_cin = c_in;
                OP_SBC: begin
                    as_inv = 1'b1;
                    as_cin = c_in;
                end
                default: ;
            endcase
        end
        case (select)
            OP_LSR, OP_ASR, OP_LSL, OP_ROR, OP_ROL: imm_res = x;
            OP_AND: imm_res = x & y;
            OP_OR:  imm_res = x | y;
            OP_XOR: imm_res = x ^ y;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                imm_res = as_sum;
                imm_c   = as_cout;
                imm_v   = as_ovf;
            end
            default: imm_res = '0;
        endcase
    end

    always_comb begin
        mstep   = lo[0] ? {as_cout, as_sum, lo} : {1'b0, acc, lo};
        nxt_acc = acc;
        nxt_lo  = lo;
        nxt_sc  = 1'b0;
        case (rop)
            OP_LSR: begin
                nxt_lo = {1'b0, lo[WIDTH-1:1]};
                nxt_sc = lo[0];
            end
            OP_ASR: begin
                nxt_lo = {lo[WIDTH-1], lo[WIDTH-1:1]};
                nxt_sc = lo[0];
            end
            OP_LSL: begin
                nxt_lo = {lo[WIDTH-2:0], 1'b0};
                nxt_sc = lo[WIDTH-1];
            end
            OP_ROR: begin
                nxt_lo = {lo[0], lo[WIDTH-1:1]};
                nxt_sc = lo[0];
            end
            OP_ROL: begin
                nxt_lo = {lo[WIDTH-2:0], lo[WIDTH-1]};
                nxt_sc = lo[WIDTH-1];
            end
            OP_MUL, OP_MULHU: {nxt_acc, nxt_lo} = mstep[2*WIDTH:1];
            default: ;
        endcase
        fin_res = (rop == OP_MULHU) ? nxt_acc : nxt_lo;
        fin_c   = nxt_sc;
        fin_v   = 1'b0;
        if (rop == OP_MUL) begin
            fin_c = |nxt_acc;
            fin_v = |nxt_acc;
        end else if (rop == OP_MULHU) begin
            fin_c = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = go_busy ? S_BUSY : S_DONE;
            end
            S_BUSY: if (last) state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            lo  <= '0;
            ry  <= '0;
            rop <= OP_LSR;
            cnt <= '0;
            res <= '0;
            cr  <= 1'b0;
            vr  <= 1'b0;
        end else if (state == S_IDLE) begin
            if (in_valid) begin
                acc <= '0;
                lo  <= x;
                ry  <= y;
                rop <= select;
                cnt <= is_mul ? CNT_MUL : {1'b0, amt};
                if (!go_busy) begin
                    res <= imm_res;
                    cr  <= imm_c;
                    vr  <= imm_v;
                end
            end
        end else if (state == S_BUSY) begin
            acc <= nxt_acc;
            lo  <= nxt_lo;
            cnt <= cnt - (SHW+1)'(1);
            if (last) begin
                res <= fin_res;
                cr  <= fin_c;
                vr  <= fin_v;
            end
        end
    end

    assign alu_out = res;
    assign c       = cr;
    assign v       = vr;
    assign n       = res[WIDTH-1];
    assign z       = ~|res;

endmodule

// File: tb/tb_crp16_alu_mc.sv
// Directed self-checking bench for crp16_alu_mc (WIDTH=16).
module tb_crp16_alu_mc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [3:0]  select = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_out;
    logic        v, c, n, z;

    int total = 0;
    int bad = 0;
    int lat;

    crp16_alu_mc #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .select    (select),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        select   = op;
        x        = a;
        y        = b;
        c_in     = ci;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x        = 16'hDEAD;
        y        = 16'hBEEF;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input int elat,
                       input logic [15:0] eres, input logic ec,
                       input logic ev);
        issue(op, a, b, ci);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_out"}, int'(alu_out), int'(eres));
        chk({tag, "_c"}, int'(c), int'(ec));
        chk({tag, "_v"}, int'(v), int'(ev));
        chk({tag, "_n"}, int'(n), int'(eres[15]));
        chk({tag, "_z"}, int'(z), int'(eres == 16'h0));
    endtask

    initial begin
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_alu_out", int'(alu_out), 0);
        chk("rst_c", int'(c), 0);
        chk("rst_v", int'(v), 0);
        chk("rst_n", int'(n), 0);
        chk("rst_z", int'(z), 1);
        #20;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run("add", 4'd6, 16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        drain();
        run("sub", 4'd7, 16'h0005, 16'h0005, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
        drain();
        run("sbc", 4'd9, 16'h0005, 16'h0005, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0);
        drain();
        run("adc", 4'd8, 16'h00FF, 16'h0001, 1'b1, 1, 16'h0101, 1'b0, 1'b0);
        drain();
        run("xor", 4'd5, 16'hF0F0, 16'hFF00, 1'b0, 1, 16'h0FF0, 1'b0, 1'b0);
        drain();
        run("asr", 4'd1, 16'h8001, 16'h0004, 1'b0, 5, 16'hF800, 1'b0, 1'b0);
        drain();
        run("lsl", 4'd2, 16'h8001, 16'h0001, 1'b0, 2, 16'h0002, 1'b1, 1'b0);
        drain();
        run("ror", 4'd10, 16'h0001, 16'h0001, 1'b0, 2, 16'h8000, 1'b1, 1'b0);
        drain();
        run("rol", 4'd11, 16'h8421, 16'h0004, 1'b0, 5, 16'h4218, 1'b0, 1'b0);
        drain();
        run("lsr0", 4'd0, 16'hA5C3, 16'h0000, 1'b0, 1, 16'hA5C3, 1'b0, 1'b0);
        drain();
        run("mul", 4'd12, 16'h0100, 16'h0100, 1'b0, 17, 16'h0000, 1'b1, 1'b1);
        drain();
        run("mulhu", 4'd13, 16'h0100, 16'h0100, 1'b0, 17, 16'h0001, 1'b0, 1'b0);
        drain();
        run("mul2", 4'd12, 16'h00FF, 16'h0003, 1'b0, 17, 16'h02FD, 1'b0, 1'b0);
        drain();
        run("rsvd", 4'd14, 16'h1234, 16'h5678, 1'b1, 1, 16'h0000, 1'b0, 1'b0);
        drain();

        run("bp", 4'd6, 16'h1234, 16'h1111, 1'b0, 1, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("bp_hold_out", int'(alu_out), 16'h2345);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_ready", int'(in_ready), 0);
        end
        select    = 4'd6;
        x         = 16'h0001;
        y         = 16'h0001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_drain_valid", int'(out_valid), 0);
        chk("bp_drain_ready", int'(in_ready), 1);
        @(posedge clock);
        #1;
        chk("bp_noacc_valid", int'(out_valid), 0);
        chk("bp_noacc_out", int'(alu_out), 16'h2345);

        run("pre", 4'd12, 16'h00FF, 16'h0003, 1'b0, 17, 16'h02FD, 1'b0, 1'b0);
        drain();
        select   = 4'd12;
        x        = 16'h0100;
        y        = 16'h0100;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_out", int'(alu_out), 0);
        chk("abort_z", int'(z), 1);
        chk("abort_ready", int'(in_ready), 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        chk("abort_noresult", int'(out_valid), 0);
        run("post", 4'd6, 16'h0003, 16'h0004, 1'b0, 1, 16'h0007, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
